// File: rtl/bullet_collision_scanner.sv
// bullet_collision_scanner
// Once per frame, snapshots bullet and enemy positions. It then checks every
// (bullet, enemy) pair for box overlap, one pair per clock. When the scan ends it
// pulses the hit vectors and done for one cycle and adds the kills to a
// saturating score.
// The pair test is split into two stages. Stage one registers the overlap of the
// current pair, which depends only on the snapshot. Stage two commits that hit
// against the accumulators. Because of this split, the pair after a hit already
// sees the updated accumulators. The extra drain cycle gives a scan_start to done
// latency of BULLET_COUNT*ENEMY_COUNT+1.
module bullet_collision_scanner #(
   parameter int BULLET_COUNT = 8,
   parameter int ENEMY_COUNT  = 4,
   parameter int BULLET_W     = 2,
   parameter int BULLET_H     = 6,
   parameter int ENEMY_W      = 16,
   parameter int ENEMY_H      = 16,
   parameter int SCORE_W      = 16
) (
   input  logic                         clk25,
   input  logic                         rst_n,
   input  logic                         scan_start,
   input  logic [10*BULLET_COUNT-1:0]   bullet_x_flat,
   input  logic [10*BULLET_COUNT-1:0]   bullet_y_flat,
   input  logic [BULLET_COUNT-1:0]      bullet_active,
   input  logic [10*ENEMY_COUNT-1:0]    enemy_x_flat,
   input  logic [10*ENEMY_COUNT-1:0]    enemy_y_flat,
   input  logic [ENEMY_COUNT-1:0]       enemy_alive,
   output logic [BULLET_COUNT-1:0]      bullet_hit,
   output logic [ENEMY_COUNT-1:0]       enemy_hit,
   output logic [SCORE_W-1:0]           score,
   output logic                         busy,
   output logic                         done
);

   localparam int IW = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
   localparam int JW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
   localparam int CW = $clog2(ENEMY_COUNT + 1);
   localparam logic [IW-1:0] I_LAST = IW'(BULLET_COUNT - 1);
   localparam logic [JW-1:0] J_LAST = JW'(ENEMY_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   // Strict box overlap in 11 bits so that x+width never wraps; touching edges miss
   function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                    input logic [9:0] ex, input logic [9:0] ey);
      logic [10:0] bx1, by1, ex1, ey1;
      bx1 = {1'b0, bx};
      by1 = {1'b0, by};
      ex1 = {1'b0, ex};
      ey1 = {1'b0, ey};
      return (bx1 < ex1 + 11'(ENEMY_W)) && (ex1 < bx1 + 11'(BULLET_W)) &&
             (by1 < ey1 + 11'(ENEMY_H)) && (ey1 < by1 + 11'(BULLET_H));
   endfunction

   function automatic logic [CW-1:0] popcount(input logic [ENEMY_COUNT-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int k = 0; k < ENEMY_COUNT; k++) begin
         c = c + CW'(v[k]);
      end
      return c;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [CW-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + (SCORE_W+1)'(b);
      if (s[SCORE_W]) begin
         return '1;
      end else begin
         return s[SCORE_W-1:0];
      end
   endfunction

   state_t                   state_q;
   logic [9:0]               bx_q [BULLET_COUNT];
   logic [9:0]               by_q [BULLET_COUNT];
   logic [9:0]               ex_q [ENEMY_COUNT];
   logic [9:0]               ey_q [ENEMY_COUNT];
   logic [BULLET_COUNT-1:0]  bact_q;
   logic [ENEMY_COUNT-1:0]   ealive_q;
   logic [IW-1:0]            i_q;
   logic [JW-1:0]            j_q;
   logic [IW-1:0]            pi_q;
   logic [JW-1:0]            pj_q;
   logic                     ovl_q;
   logic                     drain_q;
   logic [BULLET_COUNT-1:0]  hb_q;
   logic [ENEMY_COUNT-1:0]   he_q;
   logic [BULLET_COUNT-1:0]  bullet_hit_q;
   logic [ENEMY_COUNT-1:0]   enemy_hit_q;
   logic [SCORE_W-1:0]       score_q;
   logic                     busy_q;
   logic                     done_q;

   logic                     pair_ovl_s;
   logic [BULLET_COUNT-1:0]  hb_d;
   logic [ENEMY_COUNT-1:0]   he_d;
   logic [SCORE_W-1:0]       score_d;

   // Geometry of the current pair, plus commit of the previously registered pair
   always_comb begin
      pair_ovl_s = overlap(bx_q[i_q], by_q[i_q], ex_q[j_q], ey_q[j_q]) &&
                   bact_q[i_q] && ealive_q[j_q];
      hb_d = hb_q;
      he_d = he_q;
      if (ovl_q && !hb_q[pi_q] && !he_q[pj_q]) begin
         hb_d[pi_q] = 1'b1;
         he_d[pj_q] = 1'b1;
      end else begin
         hb_d = hb_q;
         he_d = he_q;
      end
      score_d = sat_add(score_q, popcount(he_d));
   end

   // Scan controller: snapshot, pair walk, accumulate, one-cycle report
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         for (int k = 0; k < BULLET_COUNT; k++) begin
            bx_q[k] <= 10'd0;
            by_q[k] <= 10'd0;
         end
         for (int k = 0; k < ENEMY_COUNT; k++) begin
            ex_q[k] <= 10'd0;
            ey_q[k] <= 10'd0;
         end
         bact_q       <= '0;
         ealive_q     <= '0;
         i_q          <= '0;
         j_q          <= '0;
         pi_q         <= '0;
         pj_q         <= '0;
         ovl_q        <= 1'b0;
         drain_q      <= 1'b0;
         hb_q         <= '0;
         he_q         <= '0;
         bullet_hit_q <= '0;
         enemy_hit_q  <= '0;
         score_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               bullet_hit_q <= '0;
               enemy_hit_q  <= '0;
               done_q       <= 1'b0;
               if (scan_start) begin
                  for (int k = 0; k < BULLET_COUNT; k++) begin
                     bx_q[k] <= bullet_x_flat[10*k +: 10];
                     by_q[k] <= bullet_y_flat[10*k +: 10];
                  end
                  for (int k = 0; k < ENEMY_COUNT; k++) begin
                     ex_q[k] <= enemy_x_flat[10*k +: 10];
                     ey_q[k] <= enemy_y_flat[10*k +: 10];
                  end
                  bact_q   <= bullet_active;
                  ealive_q <= enemy_alive;
                  hb_q     <= '0;
                  he_q     <= '0;
                  i_q      <= '0;
                  j_q      <= '0;
                  ovl_q    <= 1'b0;
                  drain_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_SCAN;
               end else begin
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               hb_q <= hb_d;
               he_q <= he_d;
               if (drain_q) begin
                  // Final pair committed this cycle; publish the forwarded result
                  ovl_q        <= 1'b0;
                  drain_q      <= 1'b0;
                  bullet_hit_q <= hb_d;
                  enemy_hit_q  <= he_d;
                  score_q      <= score_d;
                  done_q       <= 1'b1;
                  state_q      <= ST_REPORT;
               end else begin
                  ovl_q <= pair_ovl_s;
                  pi_q  <= i_q;
                  pj_q  <= j_q;
                  if (j_q == J_LAST) begin
                     j_q <= '0;
                     i_q <= i_q + IW'(1);
                  end else begin
                     j_q <= j_q + JW'(1);
                  end
                  if ((i_q == I_LAST) && (j_q == J_LAST)) begin
                     drain_q <= 1'b1;
                  end else begin
                     drain_q <= 1'b0;
                  end
               end
            end
            ST_REPORT: begin
               bullet_hit_q <= '0;
               enemy_hit_q  <= '0;
               done_q       <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: begin
               bullet_hit_q <= '0;
               enemy_hit_q  <= '0;
               done_q       <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign bullet_hit = bullet_hit_q;
   assign enemy_hit  = enemy_hit_q;
   assign score      = score_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Randomised and directed bench for bullet_collision_scanner. The reference model
// holds only the scan timeline (start edge, report 33 edges later) and computes
// each frame's hit set with plain greedy loops over the snapshot.
module tb_bullet_collision_scanner;

   logic        clk25;
   logic        rst_n;
   logic        scan_start;
   logic [79:0] bxf, byf;
   logic [7:0]  bact;
   logic [39:0] exf, eyf;
   logic [3:0]  ealive;
   logic [7:0]  bullet_hit;
   logic [3:0]  enemy_hit;
   logic [15:0] score;
   logic        busy, done;

   int pass_cnt = 0;
   int check_cnt = 0;

   // model state
   bit          m_busy = 1'b0;
   int          m_cnt = 0;
   int          m_score = 0;
   logic [7:0]  m_bh = 8'h00;
   logic [3:0]  m_eh = 4'h0;
   bit          e_done;
   int          preset_gen = 0;
   int          seen_gen = 0;
   int          preset_val = 0;

   bullet_collision_scanner dut (
      .clk25(clk25), .rst_n(rst_n), .scan_start(scan_start),
      .bullet_x_flat(bxf), .bullet_y_flat(byf), .bullet_active(bact),
      .enemy_x_flat(exf), .enemy_y_flat(eyf), .enemy_alive(ealive),
      .bullet_hit(bullet_hit), .enemy_hit(enemy_hit), .score(score),
      .busy(busy), .done(done)
   );

   initial clk25 = 1'b0;
   always #20 clk25 = ~clk25;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Greedy scan in bullet-major, enemy-minor order straight from the hit rules
   function automatic void model_hits(output logic [7:0] bh, output logic [3:0] eh);
      int bx, by, ex, ey;
      bh = 8'h00;
      eh = 4'h0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) begin
            bx = int'(bxf[10*i +: 10]);
            by = int'(byf[10*i +: 10]);
            ex = int'(exf[10*j +: 10]);
            ey = int'(eyf[10*j +: 10]);
            if (bx < ex + 16 && ex < bx + 2 && by < ey + 16 && ey < by + 6 &&
                bact[i] && ealive[j] && !bh[i] && !eh[j]) begin
               bh[i] = 1'b1;
               eh[j] = 1'b1;
            end
         end
      end
   endfunction

   // Model timeline and per-cycle compare, just after each rising edge
   always @(posedge clk25) begin
      #1;
      if (preset_gen != seen_gen) begin
         m_score  = preset_val;
         seen_gen = preset_gen;
      end
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_cnt   = 0;
         m_score = 0;
      end else if (m_busy) begin
         m_cnt++;
         if (m_cnt == 34) m_busy = 1'b0;
      end else if (scan_start) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         model_hits(m_bh, m_eh);
      end
      e_done = m_busy && (m_cnt == 33);
      if (e_done) begin
         m_score = m_score + $countones(m_eh);
         if (m_score > 65535) m_score = 65535;
      end
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("bullet_hit", {24'd0, bullet_hit}, e_done ? {24'd0, m_bh} : 32'd0);
      chk("enemy_hit", {28'd0, enemy_hit}, e_done ? {28'd0, m_eh} : 32'd0);
      chk("score", {16'd0, score}, m_score);
   end

   task automatic clear_all();
      bxf = '0; byf = '0; bact = '0;
      exf = '0; eyf = '0; ealive = '0;
   endtask

   task automatic set_b(input int k, input int x, input int y);
      bxf[10*k +: 10] = 10'(x);
      byf[10*k +: 10] = 10'(y);
      bact[k] = 1'b1;
   endtask

   task automatic set_e(input int k, input int x, input int y);
      exf[10*k +: 10] = 10'(x);
      eyf[10*k +: 10] = 10'(y);
      ealive[k] = 1'b1;
   endtask

   // Pulse scan_start (edge 0 samples it) and check the report seen after edge 33
   task automatic do_scan(input string name, input logic [7:0] ebh, input logic [3:0] eeh,
                          input logic [15:0] esc, input bit mid_move);
      @(negedge clk25);
      scan_start = 1'b1;
      @(negedge clk25);
      scan_start = 1'b0;
      for (int e = 1; e <= 33; e++) begin
         @(posedge clk25);
         if (mid_move && e == 5) begin
            @(negedge clk25);
            set_e(0, 95, 90);
         end
      end
      #1;
      chk({name, "_done"}, {31'd0, done}, 32'd1);
      chk({name, "_bh"}, {24'd0, bullet_hit}, {24'd0, ebh});
      chk({name, "_eh"}, {28'd0, enemy_hit}, {28'd0, eeh});
      chk({name, "_score"}, {16'd0, score}, {16'd0, esc});
      @(negedge clk25);
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < 8; k++) begin
         bxf[10*k +: 10] = 10'($urandom_range(135, 85));
         byf[10*k +: 10] = 10'($urandom_range(135, 85));
      end
      for (int k = 0; k < 4; k++) begin
         exf[10*k +: 10] = 10'($urandom_range(135, 85));
         eyf[10*k +: 10] = 10'($urandom_range(135, 85));
      end
      bact   = 8'($urandom);
      ealive = 4'($urandom);
   endtask

   initial begin
      int ndone;
      int done_edge;
      rst_n = 1'b0;
      scan_start = 1'b0;
      clear_all();
      repeat (3) @(negedge clk25);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_score", {16'd0, score}, 32'd0);
      rst_n = 1'b1;

      // T1 single overlap
      clear_all(); set_b(0, 100, 100); set_e(2, 95, 90);
      do_scan("t1", 8'h01, 4'h4, 16'd1, 1'b0);
      // T2 touching right edge
      clear_all(); set_b(0, 111, 100); set_e(0, 95, 90);
      do_scan("t2", 8'h00, 4'h0, 16'd1, 1'b0);
      // T3 contention: lowest bullet wins
      clear_all(); set_b(1, 100, 100); set_b(3, 100, 100); set_e(0, 95, 90);
      do_scan("t3a", 8'h02, 4'h1, 16'd2, 1'b0);
      clear_all(); set_b(1, 96, 100); set_b(3, 105, 100); set_e(0, 95, 90); set_e(1, 106, 90);
      do_scan("t3b", 8'h0A, 4'h3, 16'd4, 1'b0);
      // T4 inactive bullet, then enemy moved onto bullet mid-scan
      clear_all(); set_b(0, 100, 100); bact = 8'h00; set_e(0, 95, 90);
      do_scan("t4a", 8'h00, 4'h0, 16'd4, 1'b0);
      clear_all(); set_b(0, 100, 100); set_e(0, 500, 400);
      do_scan("t4b", 8'h00, 4'h0, 16'd4, 1'b1);

      // T5 second scan_start while busy is ignored
      clear_all(); set_b(0, 100, 100); set_e(2, 95, 90);
      @(negedge clk25);
      scan_start = 1'b1;
      @(negedge clk25);
      scan_start = 1'b0;
      ndone = 0;
      done_edge = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk25);
         #1;
         if (done) begin
            ndone++;
            done_edge = e;
         end
         if (e == 9) begin
            @(negedge clk25);
            scan_start = 1'b1;
         end else if (e == 10) begin
            @(negedge clk25);
            scan_start = 1'b0;
         end
      end
      chk("t5_ndone", ndone, 32'd1);
      chk("t5_done_edge", done_edge, 32'd33);
      chk("t5_score", {16'd0, score}, 32'd5);

      // T5 reset mid-scan
      @(negedge clk25);
      scan_start = 1'b1;
      @(negedge clk25);
      scan_start = 1'b0;
      repeat (19) @(posedge clk25);
      @(negedge clk25);
      rst_n = 1'b0;
      #1;
      chk("t5r_busy", {31'd0, busy}, 32'd0);
      chk("t5r_score", {16'd0, score}, 32'd0);
      chk("t5r_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk25);
      rst_n = 1'b1;
      ndone = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk25);
         #1;
         if (done) ndone++;
      end
      chk("t5r_nodone", ndone, 32'd0);

      // T6 saturation from a preset score
      @(negedge clk25);
      force dut.score_q = 16'hFFFE;
      preset_val = 32'hFFFE;
      preset_gen++;
      @(negedge clk25);
      release dut.score_q;
      clear_all();
      set_b(0, 100, 100); set_b(1, 200, 100); set_b(2, 300, 100);
      set_e(0, 95, 90); set_e(1, 195, 90); set_e(2, 295, 90);
      do_scan("t6a", 8'h07, 4'h7, 16'hFFFF, 1'b0);
      clear_all(); set_b(0, 100, 100); set_e(0, 95, 90);
      do_scan("t6b", 8'h01, 4'h1, 16'hFFFF, 1'b0);

      // Randomised frames with stray scan_starts and live input churn
      for (int n = 0; n < 40; n++) begin
         @(negedge clk25);
         rand_inputs();
         scan_start = 1'b1;
         for (int c = 0; c < int'($urandom_range(38, 30)); c++) begin
            @(negedge clk25);
            scan_start = ($urandom_range(3, 0) == 0);
            if ($urandom_range(7, 0) == 0) rand_inputs();
         end
         scan_start = 1'b0;
      end
      repeat (40) @(negedge clk25);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
